// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
//   Instruction fetch front end. It issues block-aligned fetch requests on the
//   instruction bus and queues the returned instructions, each with its PC and
//   exception code. The consumer sees up to N_ISSUE entries per cycle and pops
//   them with deq_count. A redirect or exception flushes the queue and restarts
//   fetching at the new PC. A response that is still outstanding when the flush
//   happens is dropped when it arrives.
//
//   Optional feature macro: INST_FETCH_QUEUE_BYPASS_EN
//     When this macro is defined and the queue is empty, a response drives the
//     outputs in the same cycle, and only the entries not consumed that cycle
//     are written to the queue. When it is undefined, the outputs come only
//     from the queue registers.
//
//   Parameters
//     BOOT_VEC  PC used after reset.
//     N_ISSUE   Instructions per fetch block, and the maximum popped per cycle
//               (1, 2 or 4).
//     DEPTH     Number of queue entries (power of two, >= 2*N_ISSUE).
//
//   Ports
//     clk, rst        Clock; asynchronous active-high reset.
//     ibus_req/addr   Fetch request and block-aligned fetch address.
//     ibus_ready      The bus accepts the request this cycle.
//     ibus_valid      Response strobe. ibus_rdata holds the block words, with
//                     lane 0 at the lowest address. ibus_ex holds
//                     {illegal, miss, invalid} for the block.
//     redirect_*      Resolved taken branch (flush).
//     except_*        Exception entry (flush; takes priority over redirect).
//     out_valid/inst/pc/ex
//                     Head-of-queue window; lane i is entry head+i.
//     deq_count       Number of entries the consumer takes this cycle.
//     count           Queue occupancy.
// -----------------------------------------------------------------------------
module inst_fetch_queue #(
  parameter logic [31:0] BOOT_VEC = 32'hbfc00000,
  parameter int          N_ISSUE  = 2,
  parameter int          DEPTH    = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic                           ibus_req,
  output logic [31:0]                    ibus_addr,
  input  logic                           ibus_ready,
  input  logic                           ibus_valid,
  input  logic [32*N_ISSUE-1:0]          ibus_rdata,
  input  logic [2:0]                     ibus_ex,
  input  logic                           redirect_valid,
  input  logic [31:0]                    redirect_pc,
  input  logic                           except_valid,
  input  logic [31:0]                    except_pc,
  output logic [N_ISSUE-1:0]             out_valid,
  output logic [32*N_ISSUE-1:0]          out_inst,
  output logic [32*N_ISSUE-1:0]          out_pc,
  output logic [3*N_ISSUE-1:0]           out_ex,
  input  logic [$clog2(N_ISSUE+1)-1:0]   deq_count,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int          BLK_BYTES = 4 * N_ISSUE;
  localparam logic [31:0] BLK_MASK  = ~(32'(BLK_BYTES) - 32'd1);
  localparam int          CW        = $clog2(DEPTH + 1);
  localparam int          PW        = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [31:0]     pc_r;
  logic [31:0]     req_pc_r;
  logic [PW-1:0]   head_r, tail_r;
  logic [CW-1:0]   count_r;
  logic [31:0]     inst_q_r [DEPTH];
  logic [31:0]     pc_q_r   [DEPTH];
  logic [2:0]      ex_q_r   [DEPTH];

  logic            flush_s;
  logic            fire_s;
  logic            resp_s;
  int              off_s;
  int              n_enq_s;
  int              q_pop_s;
  int              skip_s;
  int              n_wr_s;
  logic [31:0]     enq_inst_s [N_ISSUE];
  logic [31:0]     enq_pc_s   [N_ISSUE];
  logic [2:0]      enq_ex_s   [N_ISSUE];
`ifdef INST_FETCH_QUEUE_BYPASS_EN
  logic            byp_s;
`endif

  assign flush_s = except_valid | redirect_valid;
  // Request only when a whole block is guaranteed to fit. This gating is the
  // only overflow protection the queue has.
  assign ibus_req  = !rst && (state_r == IDLE) && !flush_s &&
                     (int'(count_r) <= DEPTH - N_ISSUE);
  assign ibus_addr = pc_r & BLK_MASK;
  assign fire_s    = ibus_req & ibus_ready;
  // A response is accepted only in WAIT and only on a non-flush cycle.
  assign resp_s    = (state_r == WAIT) && ibus_valid && !flush_s;
  assign off_s     = int'((req_pc_r >> 2) & 32'(N_ISSUE - 1));
  assign count     = count_r;
`ifdef INST_FETCH_QUEUE_BYPASS_EN
  assign byp_s     = resp_s && (count_r == '0);
`endif

  // Unpack the accepted response into the entries to enqueue, compacted to index 0.
  always_comb begin
    n_enq_s = 0;
    for (int k = 0; k < N_ISSUE; k++) begin
      enq_inst_s[k] = 32'd0;
      enq_pc_s[k]   = 32'd0;
      enq_ex_s[k]   = 3'd0;
    end
    if (resp_s) begin
      if (ibus_ex != 3'b000) begin
        // A faulting block produces one marker entry at the requested PC.
        n_enq_s       = 1;
        enq_pc_s[0]   = req_pc_r;
        enq_ex_s[0]   = ibus_ex;
      end else begin
        // Lanes below the requested PC offset are skipped (mid-block entry).
        n_enq_s = N_ISSUE - off_s;
        for (int k = 0; k < N_ISSUE; k++) begin
          if (k < N_ISSUE - off_s) begin
            enq_inst_s[k] = ibus_rdata[32*(k+off_s) +: 32];
            enq_pc_s[k]   = (req_pc_r & BLK_MASK) + 32'(4 * (k + off_s));
          end else begin
            enq_inst_s[k] = 32'd0;
          end
        end
      end
    end else begin
      n_enq_s = 0;
    end
  end

  // Decide how many entries are popped from the queue and how many from the bypass.
  always_comb begin
    q_pop_s = 0;
    skip_s  = 0;
`ifdef INST_FETCH_QUEUE_BYPASS_EN
    if (byp_s) begin
      skip_s = (int'(deq_count) < n_enq_s) ? int'(deq_count) : n_enq_s;
    end else begin
      q_pop_s = (int'(deq_count) < int'(count_r)) ? int'(deq_count) : int'(count_r);
    end
`else
    q_pop_s = (int'(deq_count) < int'(count_r)) ? int'(deq_count) : int'(count_r);
`endif
    n_wr_s = n_enq_s - skip_s;
  end

  // Fetch FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    if (flush_s) begin
      // Track the in-flight response so that it is dropped when it arrives.
      if ((state_r == WAIT || state_r == DROP) && !ibus_valid) begin
        state_nxt_s = DROP;
      end else begin
        state_nxt_s = IDLE;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (fire_s) state_nxt_s = WAIT;
          else        state_nxt_s = IDLE;
        end
        WAIT: begin
          if (ibus_valid) state_nxt_s = (ibus_ex != 3'b000) ? HALT : IDLE;
          else            state_nxt_s = WAIT;
        end
        DROP: begin
          if (ibus_valid) state_nxt_s = IDLE;
          else            state_nxt_s = DROP;
        end
        HALT:    state_nxt_s = HALT;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Fetch state, fetch PC and the PC of the outstanding request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      pc_r     <= BOOT_VEC;
      req_pc_r <= BOOT_VEC;
    end else begin
      state_r <= state_nxt_s;
      if (flush_s) begin
        pc_r <= except_valid ? except_pc : redirect_pc;
      end else if (fire_s) begin
        pc_r <= (pc_r & BLK_MASK) + 32'(BLK_BYTES);
      end else begin
        pc_r <= pc_r;
      end
      if (fire_s) req_pc_r <= pc_r;
      else        req_pc_r <= req_pc_r;
    end
  end

  // Queue storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        inst_q_r[e] <= 32'd0;
        pc_q_r[e]   <= 32'd0;
        ex_q_r[e]   <= 3'd0;
      end
    end else if (flush_s) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      for (int k = 0; k < N_ISSUE; k++) begin
        if (k < n_wr_s) begin
          inst_q_r[PW'(tail_r + PW'(k))] <= enq_inst_s[k + skip_s];
          pc_q_r[PW'(tail_r + PW'(k))]   <= enq_pc_s[k + skip_s];
          ex_q_r[PW'(tail_r + PW'(k))]   <= enq_ex_s[k + skip_s];
        end
      end
      tail_r  <= tail_r + PW'(n_wr_s);
      head_r  <= head_r + PW'(q_pop_s);
      count_r <= count_r + CW'(n_wr_s) - CW'(q_pop_s);
    end
  end

  // Output window: lane i shows queue entry head+i (or the bypassed response).
  always_comb begin
    for (int i = 0; i < N_ISSUE; i++) begin
`ifdef INST_FETCH_QUEUE_BYPASS_EN
      if (byp_s) begin
        out_valid[i]        = (i < n_enq_s);
        out_inst[32*i +: 32] = enq_inst_s[i];
        out_pc[32*i +: 32]   = enq_pc_s[i];
        out_ex[3*i +: 3]     = enq_ex_s[i];
      end else begin
        out_valid[i]        = (int'(count_r) > i);
        out_inst[32*i +: 32] = inst_q_r[PW'(head_r + PW'(i))];
        out_pc[32*i +: 32]   = pc_q_r[PW'(head_r + PW'(i))];
        out_ex[3*i +: 3]     = ex_q_r[PW'(head_r + PW'(i))];
      end
`else
      out_valid[i]        = (int'(count_r) > i);
      out_inst[32*i +: 32] = inst_q_r[PW'(head_r + PW'(i))];
      out_pc[32*i +: 32]   = pc_q_r[PW'(head_r + PW'(i))];
      out_ex[3*i +: 3]     = ex_q_r[PW'(head_r + PW'(i))];
`endif
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_queue
//   Directed testbench for inst_fetch_queue with N_ISSUE=2 and DEPTH=8. The
//   expected values are worked out by hand from the intended behaviour. The
//   instruction words are derived from their PC with word_of().
// -----------------------------------------------------------------------------
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_ready;
  logic        ibus_valid;
  logic [63:0] ibus_rdata;
  logic [2:0]  ibus_ex;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        except_valid;
  logic [31:0] except_pc;
  logic [1:0]  out_valid;
  logic [63:0] out_inst;
  logic [63:0] out_pc;
  logic [5:0]  out_ex;
  logic [1:0]  deq_count;
  logic [3:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  inst_fetch_queue #(
    .BOOT_VEC (32'hbfc00000),
    .N_ISSUE  (2),
    .DEPTH    (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ibus_req       (ibus_req),
    .ibus_addr      (ibus_addr),
    .ibus_ready     (ibus_ready),
    .ibus_valid     (ibus_valid),
    .ibus_rdata     (ibus_rdata),
    .ibus_ex        (ibus_ex),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .except_valid   (except_valid),
    .except_pc      (except_pc),
    .out_valid      (out_valid),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_ex         (out_ex),
    .deq_count      (deq_count),
    .count          (count)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and count it.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5a5a0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fire one request (ibus_req must already be high), then respond next cycle.
  task automatic fetch_resp(input logic [31:0] blk);
    ibus_ready = 1'b1;
    tick();
    ibus_ready = 1'b0;
    ibus_valid = 1'b1;
    ibus_rdata = {word_of(blk + 32'd4), word_of(blk)};
    tick();
    ibus_valid = 1'b0;
  endtask

  // Hard stop, in case the sequence below ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  // Directed stimulus and checks.
  initial begin
    rst = 1'b1;
    ibus_ready = 1'b1;
    ibus_valid = 1'b0;
    ibus_rdata = 64'd0;
    ibus_ex = 3'b000;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    except_valid = 1'b0;
    except_pc = 32'd0;
    deq_count = 2'd0;

    // Reset state
    tick();
    chk("rst_req",   32'(ibus_req),  32'd0);
    chk("rst_addr",  ibus_addr,      32'hbfc00000);
    chk("rst_count", 32'(count),     32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);

    // First fetch after reset
    rst = 1'b0;
    #1;
    chk("boot_req",  32'(ibus_req), 32'd1);
    chk("boot_addr", ibus_addr,     32'hbfc00000);
    tick();
    ibus_ready = 1'b0;
    ibus_valid = 1'b1;
    ibus_rdata = {word_of(32'hbfc00004), word_of(32'hbfc00000)};
    #1;
    chk("wait_req",   32'(ibus_req),  32'd0);
    chk("lat_valid0", 32'(out_valid), 32'd0);
    tick();
    ibus_valid = 1'b0;
    #1;
    chk("boot_valid", 32'(out_valid),   32'd3);
    chk("boot_count", 32'(count),       32'd2);
    chk("boot_pc0",   out_pc[31:0],     32'hbfc00000);
    chk("boot_pc1",   out_pc[63:32],    32'hbfc00004);
    chk("boot_inst1", out_inst[63:32],  word_of(32'hbfc00004));
    chk("next_addr",  ibus_addr,        32'hbfc00008);
    chk("next_req",   32'(ibus_req),    32'd1);

    // Redirect into the middle of a block
    redirect_valid = 1'b1;
    redirect_pc = 32'h80000004;
    deq_count = 2'd2;
    #1;
    chk("flush_req", 32'(ibus_req), 32'd0);
    tick();
    redirect_valid = 1'b0;
    deq_count = 2'd0;
    #1;
    chk("redir_count", 32'(count),     32'd0);
    chk("redir_valid", 32'(out_valid), 32'd0);
    chk("redir_addr",  ibus_addr,      32'h80000000);
    chk("redir_req",   32'(ibus_req),  32'd1);
    ibus_ready = 1'b1;
    tick();
    ibus_ready = 1'b0;
    ibus_valid = 1'b1;
    ibus_rdata = {32'hbbbb0001, 32'haaaa0001};
    tick();
    ibus_valid = 1'b0;
    #1;
    chk("mid_count", 32'(count),      32'd1);
    chk("mid_valid", 32'(out_valid),  32'd1);
    chk("mid_inst",  out_inst[31:0],  32'hbbbb0001);
    chk("mid_pc",    out_pc[31:0],    32'h80000004);
    chk("mid_ex",    32'(out_ex),     32'd0);
    chk("mid_addr",  ibus_addr,       32'h80000008);

    // Fill to saturation with pointer wrap, then drain and resume
    deq_count = 2'd1;
    tick();
    deq_count = 2'd0;
    #1;
    chk("drain_count", 32'(count), 32'd0);
    for (int b = 0; b < 4; b++) begin
      chk("fill_req", 32'(ibus_req), 32'd1);
      fetch_resp(32'h80000008 + 32'(8 * b));
      #1;
      chk("fill_count", 32'(count), 32'(2 * (b + 1)));
    end
    chk("full_req",   32'(ibus_req),  32'd0);
    chk("full_pc0",   out_pc[31:0],   32'h80000008);
    chk("full_pc1",   out_pc[63:32],  32'h8000000c);
    chk("full_inst1", out_inst[63:32], word_of(32'h8000000c));
    tick();
    chk("hold_count", 32'(count),     32'd8);
    chk("hold_req",   32'(ibus_req),  32'd0);
    chk("hold_valid", 32'(out_valid), 32'd3);
    deq_count = 2'd2;
    tick();
    deq_count = 2'd0;
    #1;
    chk("deq_count6", 32'(count),    32'd6);
    chk("deq_pc0",    out_pc[31:0],  32'h80000010);
    chk("resume_req", 32'(ibus_req), 32'd1);
    chk("resume_addr", ibus_addr,    32'h80000028);
    // Enqueue and dequeue in the same cycle
    ibus_ready = 1'b1;
    tick();
    ibus_ready = 1'b0;
    ibus_valid = 1'b1;
    ibus_rdata = {word_of(32'h8000002c), word_of(32'h80000028)};
    deq_count = 2'd1;
    tick();
    ibus_valid = 1'b0;
    deq_count = 2'd0;
    #1;
    chk("net_count", 32'(count),   32'd7);
    chk("net_pc0",   out_pc[31:0], 32'h80000014);

    // Exception while a request is outstanding; the late response is dropped
    redirect_valid = 1'b1;
    redirect_pc = 32'h90000000;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("clr_count", 32'(count),    32'd0);
    chk("clr_req",   32'(ibus_req), 32'd1);
    ibus_ready = 1'b1;
    tick();
    ibus_ready = 1'b0;
    except_valid = 1'b1;
    except_pc = 32'hbfc00380;
    #1;
    chk("exc_req", 32'(ibus_req), 32'd0);
    tick();
    except_valid = 1'b0;
    #1;
    chk("drop_req", 32'(ibus_req), 32'd0);
    tick();
    tick();
    ibus_valid = 1'b1;
    ibus_rdata = {32'hdead0002, 32'hdead0001};
    tick();
    ibus_valid = 1'b0;
    #1;
    chk("drop_count", 32'(count),     32'd0);
    chk("drop_valid", 32'(out_valid), 32'd0);
    chk("exc_next_req",  32'(ibus_req), 32'd1);
    chk("exc_next_addr", ibus_addr,     32'hbfc00380);

    // Faulting response: one marker entry, then HALT until redirect
    ibus_ready = 1'b1;
    tick();
    ibus_ready = 1'b0;
    ibus_valid = 1'b1;
    ibus_ex = 3'b100;
    ibus_rdata = {32'h12345678, 32'h9abcdef0};
    tick();
    ibus_valid = 1'b0;
    ibus_ex = 3'b000;
    #1;
    chk("ex_count", 32'(count),      32'd1);
    chk("ex_valid", 32'(out_valid),  32'd1);
    chk("ex_code",  32'(out_ex[2:0]), 32'd4);
    chk("ex_inst",  out_inst[31:0],  32'd0);
    chk("ex_pc",    out_pc[31:0],    32'hbfc00380);
    chk("halt_req", 32'(ibus_req),   32'd0);
    ibus_ready = 1'b1;
    tick();
    tick();
    chk("halt_req2", 32'(ibus_req), 32'd0);
    deq_count = 2'd2;
    tick();
    deq_count = 2'd0;
    #1;
    chk("minpop_count", 32'(count),    32'd0);
    chk("halt_req3",    32'(ibus_req), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h80001000;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("unhalt_req",  32'(ibus_req), 32'd1);
    chk("unhalt_addr", ibus_addr,     32'h80001000);

    // Reset while WAIT: the stale response must not be enqueued
    tick();
    ibus_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("wrst_req",  32'(ibus_req), 32'd0);
    chk("wrst_addr", ibus_addr,     32'hbfc00000);
    tick();
    rst = 1'b0;
    ibus_valid = 1'b1;
    ibus_rdata = {32'hdead0004, 32'hdead0003};
    tick();
    ibus_valid = 1'b0;
    #1;
    chk("wrst_count", 32'(count),     32'd0);
    chk("wrst_valid", 32'(out_valid), 32'd0);
    chk("wrst_req2",  32'(ibus_req),  32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 SHALL have parameter BOOT_VEC, default 32'hbfc00000, reset fetch PC.
REQ-002 SHALL have parameter N_ISSUE, default 2, instructions per fetch block and max dequeue per cycle (1, 2 or 4).
REQ-003 SHALL have parameter DEPTH, default 8, queue entries (power of two, >= 2*N_ISSUE).
REQ-004 SHALL have ports: clk in 1, clock; rst in 1, reset.
REQ-005 SHALL have ports: ibus_req out 1, fetch request; ibus_addr out 32, block-aligned fetch address; ibus_ready in 1, request accepted.
REQ-006 SHALL have ports: ibus_valid in 1, response strobe; ibus_rdata in 32*N_ISSUE, block words, lane 0 at lowest address; ibus_ex in 3, {illegal, miss, invalid} for the block.
REQ-007 SHALL have ports: redirect_valid in 1, resolved taken branch; redirect_pc in 32; except_valid in 1; except_pc in 32.
REQ-008 SHALL have ports: out_valid out N_ISSUE; out_inst out 32*N_ISSUE; out_pc out 32*N_ISSUE; out_ex out 3*N_ISSUE; deq_count in clog2(N_ISSUE+1), entries consumed this cycle; count out clog2(DEPTH+1), occupancy.
REQ-009 SHALL use one clock; reset is asynchronous and active-high.

Function
REQ-010 SHALL hold fetch state in FSM states IDLE, WAIT, DROP and HALT.
REQ-011 In IDLE, ibus_req SHALL be 1 when DEPTH-count >= N_ISSUE and no flush is active; ibus_addr SHALL equal pc with its low log2(4*N_ISSUE) bits cleared.
REQ-012 On ibus_req&ibus_ready, SHALL latch req_pc=pc, set pc to ibus_addr+4*N_ISSUE and enter WAIT.
REQ-013 In WAIT on ibus_valid with ibus_ex==0, SHALL enqueue lanes off..N_ISSUE-1 (off = req_pc[log2(4N)-1:2]) with pc=ibus_addr+4*lane, ex=0, and return to IDLE.
REQ-014 In WAIT on ibus_valid with ibus_ex!=0, SHALL enqueue exactly one entry (pc=req_pc, inst=0, ex=ibus_ex) and enter HALT; HALT issues no requests.
REQ-015 ibus_valid outside WAIT/DROP SHALL be ignored.
REQ-016 Lane i of the output SHALL show entry head+i mod DEPTH; out_valid[i]=(count>i).
REQ-017 On a non-flush cycle, SHALL pop min(deq_count, count) entries; enqueue and dequeue in one cycle SHALL update count by the net difference.
REQ-018 Pointers SHALL wrap modulo DEPTH; request gating (REQ-011) SHALL guarantee no overflow.
REQ-019 Flush = except_valid|redirect_valid: count, head and tail SHALL go to 0; pc SHALL load except_pc if except_valid, else redirect_pc; deq_count and any same-cycle response SHALL be ignored.
REQ-020 Flush in WAIT without same-cycle ibus_valid SHALL enter DROP; otherwise the next state SHALL be IDLE; HALT SHALL exit only on flush.
REQ-021 In DROP the next ibus_valid SHALL be discarded and the state SHALL go to IDLE; a flush in DROP SHALL stay in DROP, reloading pc.
REQ-022 Latency: a response in cycle t SHALL appear on out_valid in t+1.

Reset
REQ-023 Reset SHALL force state IDLE, pc=BOOT_VEC, count/head/tail=0, out_valid=0, ibus_req=0 for the reset cycle, ibus_addr=BOOT_VEC aligned.
REQ-024 Reset during WAIT SHALL abandon the request; no later response SHALL be enqueued until a new request fires.

Configuration
REQ-025 Macro INST_FETCH_QUEUE_BYPASS_EN: when defined and count==0, a valid non-flush response SHALL drive outputs combinationally in cycle t (latency 0), deq_count SHALL consume from it, and only unconsumed entries SHALL be enqueued.
REQ-026 Without INST_FETCH_QUEUE_BYPASS_EN, latency SHALL be exactly REQ-022 and outputs SHALL depend only on queue registers.

Verification (N_ISSUE=2, DEPTH=8)
REQ-027 Release reset, ibus_ready=1 -> ibus_addr=32'hbfc00000, req fires; response next cycle -> out_pc 0xbfc00000/0xbfc00004 valid one cycle later, count=2.
REQ-028 redirect_pc=0x80000004, response words A,B -> one entry, inst B, pc 0x80000004; next ibus_addr 0x80000008.
REQ-029 deq_count=0 sustained -> count saturates at 8, ibus_req=0 at count>6; deq_count=2 -> count 6, request resumes.
REQ-030 except_valid with except_pc=0xbfc00380 while WAIT, response arrives 3 cycles later -> discarded, count=0, next ibus_addr=0xbfc00380.
REQ-031 ibus_ex=3'b100 response -> one entry with out_ex=3'b100, inst=0, ibus_req stays 0 until redirect_valid.
